// File: rtl/layer_sequencer_if.sv
`default_nettype none
// layer_sequencer_if: handshake bundle between the layer sequencer and the weight/conv/bn engines.
// Revision 1.0
interface layer_sequencer_if #(
  parameter int LAYER_W = 4
);
  logic               wload_req;
  logic [LAYER_W-1:0] wload_layer;
  logic               wload_done;
  logic               conv_start;
  logic               conv_done;
  logic               bn_start;
  logic               bn_done;

  modport master (
    output wload_req, wload_layer, conv_start, bn_start,
    input  wload_done, conv_done, bn_done
  );

  modport slave (
    input  wload_req, wload_layer, conv_start, bn_start,
    output wload_done, conv_done, bn_done
  );
endinterface
`default_nettype wire

// File: rtl/layer_sequencer.sv
`default_nettype none
// layer_sequencer: walks the network layer by layer (weight load -> conv -> batch-norm) with timeout/abort.
// Revision 1.0
module layer_sequencer #(
  parameter int NUM_LAYERS    = 11,
  parameter int LAYER_W       = 4,
  parameter int TIMEOUT_LIMIT = 100000,
  parameter int CNT_W         = 32
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  input  wire logic               start,
  input  wire logic               abort,
  input  wire logic               memory_ready,
  layer_sequencer_if.master       eng,
  output logic [LAYER_W-1:0]      layer_idx,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [1:0]              error_code,
  output logic [CNT_W-1:0]        cycle_count
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_W = 3'd1;
  localparam logic [2:0] S_CONV   = 3'd2;
  localparam logic [2:0] S_BN     = 3'd3;
  localparam logic [2:0] S_NEXT   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  localparam int                ST_W           = $clog2(TIMEOUT_LIMIT + 1);
  localparam logic [ST_W-1:0]    C_STAGE_LAST   = ST_W'(TIMEOUT_LIMIT - 1);
  localparam logic [LAYER_W-1:0] C_LAYER_LAST   = LAYER_W'(NUM_LAYERS - 1);
  localparam logic [1:0]         C_ERR_NONE     = 2'b00;
  localparam logic [1:0]         C_ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0]         C_ERR_SPURIOUS = 2'b10;

  logic [2:0]         r_state, w_next;
  logic [1:0]         w_err_cause;
  logic [ST_W-1:0]    r_stage;
  logic [LAYER_W-1:0] r_layer, w_layer_next;
  logic [CNT_W-1:0]   r_cycles;
  logic               w_expected, w_spurious, w_timeout, w_in_run;

  logic               r_wload_req, r_conv_start, r_bn_start, r_busy, r_done, r_error;
  logic               w_wload_req, w_conv_start, w_bn_start, w_busy, w_done, w_error;
  logic [1:0]         r_error_code, w_error_code;
  logic [LAYER_W-1:0] r_wload_layer;

  // Classify the engine done pulses against the stage currently being waited on.
  always_comb begin
    w_expected = 1'b0;
    w_spurious = 1'b0;
    case (r_state)
      S_LOAD_W: begin
        w_expected = eng.wload_done;
        w_spurious = eng.conv_done | eng.bn_done;
      end
      S_CONV: begin
        w_expected = eng.conv_done;
        w_spurious = eng.wload_done | eng.bn_done;
      end
      S_BN: begin
        w_expected = eng.bn_done;
        w_spurious = eng.wload_done | eng.conv_done;
      end
      default: ;
    endcase
    w_timeout = (r_stage == C_STAGE_LAST);
    w_in_run  = (r_state == S_LOAD_W) || (r_state == S_CONV) || (r_state == S_BN) ||
                (r_state == S_NEXT) || (r_state == S_DONE);
  end

  // Next state: abort > spurious > expected done > timeout.
  always_comb begin
    w_next       = r_state;
    w_err_cause  = C_ERR_NONE;
    w_layer_next = r_layer;
    if (abort && (r_state != S_IDLE)) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (start && memory_ready) begin
          w_next       = S_LOAD_W;
          w_layer_next = '0;
        end
        S_LOAD_W, S_CONV, S_BN: begin
          if (w_spurious) begin
            w_next      = S_ERROR;
            w_err_cause = C_ERR_SPURIOUS;
          end else if (w_expected) begin
            w_next = (r_state == S_LOAD_W) ? S_CONV : (r_state == S_CONV) ? S_BN : S_NEXT;
          end else if (w_timeout) begin
            w_next      = S_ERROR;
            w_err_cause = C_ERR_TIMEOUT;
          end
        end
        S_NEXT: begin
          if (r_layer == C_LAYER_LAST) begin
            w_next = S_DONE;
          end else begin
            w_next       = S_LOAD_W;
            w_layer_next = r_layer + LAYER_W'(1);
          end
        end
        S_DONE:  w_next = S_IDLE;
        S_ERROR: w_next = S_ERROR;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stage  <= '0;
      r_layer  <= '0;
      r_cycles <= '0;
    end else begin
      r_layer <= w_layer_next;
      if (w_next != r_state) begin
        r_stage <= '0;
      end else if ((r_state == S_LOAD_W) || (r_state == S_CONV) || (r_state == S_BN)) begin
        r_stage <= r_stage + ST_W'(1);
      end
      if ((r_state == S_IDLE) && (w_next == S_LOAD_W)) begin
        r_cycles <= '0;
      end else if (w_in_run && (r_cycles != {CNT_W{1'b1}})) begin
        r_cycles <= r_cycles + CNT_W'(1);
      end
    end
  end

  // Outputs are decoded from the upcoming state so they appear registered with the state.
  always_comb begin
    w_wload_req  = (w_next == S_LOAD_W);
    w_conv_start = (w_next == S_CONV) && (r_state != S_CONV);
    w_bn_start   = (w_next == S_BN) && (r_state != S_BN);
    w_busy       = (w_next == S_LOAD_W) || (w_next == S_CONV) ||
                   (w_next == S_BN) || (w_next == S_NEXT);
    w_done       = (w_next == S_DONE);
    w_error      = (w_next == S_ERROR);
    w_error_code = C_ERR_NONE;
    if (w_next == S_ERROR) begin
      w_error_code = (r_state == S_ERROR) ? r_error_code : w_err_cause;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wload_req   <= 1'b0;
      r_wload_layer <= '0;
      r_conv_start  <= 1'b0;
      r_bn_start    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_error_code  <= C_ERR_NONE;
    end else begin
      r_wload_req   <= w_wload_req;
      r_wload_layer <= w_layer_next;
      r_conv_start  <= w_conv_start;
      r_bn_start    <= w_bn_start;
      r_busy        <= w_busy;
      r_done        <= w_done;
      r_error       <= w_error;
      r_error_code  <= w_error_code;
    end
  end

  assign eng.wload_req   = r_wload_req;
  assign eng.wload_layer = r_wload_layer;
  assign eng.conv_start  = r_conv_start;
  assign eng.bn_start    = r_bn_start;
  assign layer_idx       = r_layer;
  assign busy            = r_busy;
  assign done            = r_done;
  assign error           = r_error;
  assign error_code      = r_error_code;
  assign cycle_count     = r_cycles;
endmodule
`default_nettype wire

// File: tb/tb_layer_sequencer.sv
`default_nettype none
// tb_layer_sequencer: randomized-latency engine responder with a cycle/pulse reference model.
// Revision 1.0
module tb_layer_sequencer;
  localparam int NL = 3;
  localparam int LW = 4;
  localparam int TO = 16;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n, start, abort, memory_ready;
  logic [LW-1:0] layer_idx;
  logic          busy, done, error;
  logic [1:0]    error_code;
  logic [CW-1:0] cycle_count;

  layer_sequencer_if #(.LAYER_W(LW)) eng ();

  layer_sequencer #(
    .NUM_LAYERS(NL), .LAYER_W(LW), .TIMEOUT_LIMIT(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .memory_ready(memory_ready),
    .eng(eng), .layer_idx(layer_idx), .busy(busy), .done(done), .error(error),
    .error_code(error_code), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int n_conv = 0, n_bn = 0, n_done = 0;

  always @(negedge clk) begin
    if (eng.conv_start) n_conv++;
    if (eng.bn_start)   n_bn++;
    if (done)           n_done++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the first cycle of a wait stage; the done pulse lands in cycle 'lat'.
  task automatic pulse_after(input int lat, input int which, input bit noise);
    repeat (lat - 1) begin
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    start = 1'b0;
    case (which)
      0:       eng.wload_done = 1'b1;
      1:       eng.conv_done  = 1'b1;
      default: eng.bn_done    = 1'b1;
    endcase
    tick();
    eng.wload_done = 1'b0;
    eng.conv_done  = 1'b0;
    eng.bn_done    = 1'b0;
  endtask

  task automatic start_run();
    memory_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_layer();
    pulse_after($urandom_range(1, 6), 0, 1'b0);
    pulse_after($urandom_range(1, 6), 1, 1'b0);
    pulse_after($urandom_range(1, 6), 2, 1'b0);
    tick();
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; memory_ready = 1'b0;
    eng.wload_done = 1'b0; eng.conv_done = 1'b0; eng.bn_done = 1'b0;
    repeat (3) tick();
    vectors++; if ({eng.wload_req, eng.conv_start, eng.bn_start, busy, done, error} !== 6'b0) begin miscompares++; $display("FAIL reset_flags: got %b want 000000", {eng.wload_req, eng.conv_start, eng.bn_start, busy, done, error}); end
    vectors++; if ({layer_idx, error_code, eng.wload_layer} !== '0) begin miscompares++; $display("FAIL reset_fields: layer %0d code %0d wlayer %0d want 0", layer_idx, error_code, eng.wload_layer); end
    vectors++; if (cycle_count !== '0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", cycle_count); end
    rst_n = 1'b1;
    tick();
  endtask

  // Expected run length = sum of stage latencies + one NEXT per layer + one DONE cycle.
  task automatic test_full_run(input int runs);
    int exp_cyc, lat, c0, b0, d0;
    for (int r = 0; r < runs; r++) begin
      exp_cyc = 0; c0 = n_conv; b0 = n_bn; d0 = n_done;
      start_run();
      for (int l = 0; l < NL; l++) begin
        vectors++; if (eng.wload_req !== 1'b1 || eng.wload_layer !== LW'(l)) begin miscompares++; $display("FAIL run_wload: req %b layer %0d want 1 layer %0d", eng.wload_req, eng.wload_layer, l); end
        lat = $urandom_range(1, 10); pulse_after(lat, 0, 1'b1); exp_cyc += lat;
        vectors++; if (eng.conv_start !== 1'b1) begin miscompares++; $display("FAIL run_conv_start: got %b want 1 (layer %0d)", eng.conv_start, l); end
        lat = $urandom_range(1, 10); pulse_after(lat, 1, 1'b1); exp_cyc += lat;
        vectors++; if (eng.bn_start !== 1'b1) begin miscompares++; $display("FAIL run_bn_start: got %b want 1 (layer %0d)", eng.bn_start, l); end
        lat = $urandom_range(1, 10); pulse_after(lat, 2, 1'b1); exp_cyc += lat + 1;
        vectors++; if (busy !== 1'b1 || layer_idx !== LW'(l)) begin miscompares++; $display("FAIL run_next: busy %b layer %0d want 1 layer %0d", busy, layer_idx, l); end
        tick();
      end
      exp_cyc += 1;
      vectors++; if (done !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL run_done: done %b busy %b want 1 0", done, busy); end
      tick();
      vectors++; if (done !== 1'b0 || busy !== 1'b0 || layer_idx !== LW'(NL - 1)) begin miscompares++; $display("FAIL run_idle: done %b busy %b layer %0d want 0 0 %0d", done, busy, layer_idx, NL - 1); end
      vectors++; if (cycle_count !== CW'(exp_cyc)) begin miscompares++; $display("FAIL run_cycles: got %0d want %0d", cycle_count, exp_cyc); end
      vectors++; if (n_conv - c0 != NL || n_bn - b0 != NL || n_done - d0 != 1) begin miscompares++; $display("FAIL run_pulses: conv %0d bn %0d done %0d want %0d %0d 1", n_conv - c0, n_bn - b0, n_done - d0, NL, NL); end
      repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  task automatic test_start_rejected();
    memory_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    vectors++; if (busy !== 1'b0 || eng.wload_req !== 1'b0) begin miscompares++; $display("FAIL nomem_start: busy %b req %b want 0 0", busy, eng.wload_req); end
    memory_ready = 1'b1;
    repeat (3) tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL nomem_latch: busy %b want 0", busy); end
  endtask

  task automatic test_timeout();
    int d0;
    d0 = n_done;
    start_run();
    run_layer();
    pulse_after($urandom_range(1, 6), 0, 1'b0);
    repeat (TO - 1) tick();
    vectors++; if (error !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL timeout_early: error %b busy %b want 0 1", error, busy); end
    tick();
    vectors++; if (error !== 1'b1 || error_code !== 2'b01 || busy !== 1'b0 || eng.wload_req !== 1'b0) begin miscompares++; $display("FAIL timeout_err: error %b code %b busy %b want 1 01 0", error, error_code, busy); end
    start = 1'b1; tick(); start = 1'b0;
    vectors++; if (error !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL error_start: error %b busy %b want 1 0", error, busy); end
    do_abort();
    vectors++; if (error !== 1'b0 || error_code !== 2'b00 || busy !== 1'b0 || n_done != d0) begin miscompares++; $display("FAIL timeout_abort: error %b code %b busy %b dones %0d want 0 00 0 0", error, error_code, busy, n_done - d0); end
  endtask

  task automatic test_done_beats_timeout();
    start_run();
    pulse_after($urandom_range(1, 6), 0, 1'b0);
    pulse_after(TO, 1, 1'b0);
    vectors++; if (eng.bn_start !== 1'b1 || error !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL edge_done: bn_start %b error %b busy %b want 1 0 1", eng.bn_start, error, busy); end
    do_abort();
  endtask

  task automatic test_spurious();
    start_run();
    eng.bn_done = 1'b1; tick(); eng.bn_done = 1'b0;
    vectors++; if (error !== 1'b1 || error_code !== 2'b10 || eng.wload_req !== 1'b0) begin miscompares++; $display("FAIL spur_load: error %b code %b req %b want 1 10 0", error, error_code, eng.wload_req); end
    do_abort();
    start_run();
    pulse_after($urandom_range(1, 6), 0, 1'b0);
    eng.conv_done = 1'b1; eng.wload_done = 1'b1; tick();
    eng.conv_done = 1'b0; eng.wload_done = 1'b0;
    vectors++; if (error !== 1'b1 || error_code !== 2'b10 || eng.bn_start !== 1'b0) begin miscompares++; $display("FAIL spur_both: error %b code %b bn_start %b want 1 10 0", error, error_code, eng.bn_start); end
    do_abort();
  endtask

  task automatic test_abort_conv();
    int b0, d0;
    start_run();
    run_layer();
    run_layer();
    pulse_after($urandom_range(1, 6), 0, 1'b0);
    repeat ($urandom_range(0, 4)) tick();
    b0 = n_bn; d0 = n_done;
    eng.conv_done = 1'b1; abort = 1'b1; tick();
    eng.conv_done = 1'b0; abort = 1'b0;
    vectors++; if (busy !== 1'b0 || eng.bn_start !== 1'b0 || done !== 1'b0 || error !== 1'b0 || layer_idx !== LW'(2)) begin miscompares++; $display("FAIL abort_conv: busy %b bn %b done %b err %b layer %0d want 0 0 0 0 2", busy, eng.bn_start, done, error, layer_idx); end
    repeat (4) tick();
    vectors++; if (n_bn != b0 || n_done != d0 || layer_idx !== LW'(2)) begin miscompares++; $display("FAIL abort_hold: bn %0d done %0d layer %0d want 0 0 2", n_bn - b0, n_done - d0, layer_idx); end
    start_run();
    vectors++; if (layer_idx !== '0 || eng.wload_layer !== '0 || cycle_count !== '0) begin miscompares++; $display("FAIL abort_restart: layer %0d wlayer %0d cnt %0d want 0 0 0", layer_idx, eng.wload_layer, cycle_count); end
    do_abort();
  endtask

  task automatic test_reset_midrun();
    int d0;
    d0 = n_done;
    start_run();
    pulse_after($urandom_range(1, 6), 0, 1'b0);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    vectors++; if ({busy, eng.wload_req, eng.conv_start, done} !== 4'b0 || cycle_count !== '0 || n_done != d0) begin miscompares++; $display("FAIL midrun_reset: flags %b cnt %0d dones %0d want 0000 0 0", {busy, eng.wload_req, eng.conv_start, done}, cycle_count, n_done - d0); end
    tick();
  endtask

  initial begin
    test_reset();
    test_full_run(4);
    test_start_rejected();
    test_timeout();
    test_done_beats_timeout();
    test_spurious();
    test_abort_conv();
    test_reset_midrun();
    test_full_run(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
